// File: rtl/alu_decoder_md.sv
// rtl/alu_decoder_md.sv - MIPS ALU decoder with iterative multiply/divide unit and HI/LO registers
module alu_decoder_md #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [3:0]       ALUControl,
    output logic             md_sel,
    output logic [WIDTH-1:0] md_result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             stall,
    output logic             illegal
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc_hi, acc_lo, dvs;
    logic               op_div, op_sgn, neg_a, neg_b, dz;

    logic               md_op, is_mfhi, is_mflo, is_mthi, is_mtlo;

    always_comb begin
        ALUControl = 4'b0010;
        illegal    = 1'b0;
        case (ALUOp)
            2'b00: ALUControl = 4'b0010;
            2'b01: ALUControl = 4'b0110;
            2'b11: ALUControl = 4'b0001;
            default: begin
                case (funct)
                    6'b100000, 6'b100001: ALUControl = 4'b0010;
                    6'b100010, 6'b100011: ALUControl = 4'b0110;
                    6'b100100: ALUControl = 4'b0000;
                    6'b100101: ALUControl = 4'b0001;
                    6'b100110: ALUControl = 4'b0011;
                    6'b100111: ALUControl = 4'b1100;
                    6'b101010: ALUControl = 4'b0111;
                    6'b101011: ALUControl = 4'b1111;
                    6'b000000: ALUControl = 4'b1000;
                    6'b000010: ALUControl = 4'b1001;
                    6'b000011: ALUControl = 4'b1010;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011,
                    6'b010000, 6'b010001, 6'b010010, 6'b010011:
                        ALUControl = 4'b0010;
                    default: illegal = 1'b1;
                endcase
            end
        endcase
    end

    assign md_op   = (ALUOp == 2'b10) && (funct[5:2] == 4'b0110);
    assign is_mfhi = (ALUOp == 2'b10) && (funct == 6'b010000);
    assign is_mflo = (ALUOp == 2'b10) && (funct == 6'b010010);
    assign is_mthi = (ALUOp == 2'b10) && (funct == 6'b010001);
    assign is_mtlo = (ALUOp == 2'b10) && (funct == 6'b010011);

    assign md_sel    = is_mfhi | is_mflo;
    assign md_result = is_mfhi ? hi : (is_mflo ? lo : '0);
    assign stall     = rst_n & (((state == IDLE) & en & md_op) | (state == BUSY));

    // One iteration: multiply shifts the product right, divide shifts the quotient left.
    logic [WIDTH:0]     add_sum, shifted, diff;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fin_hi, fin_lo;
    logic               sign_diff;

    always_comb begin
        add_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dvs} : '0);
        shifted   = {acc_hi, acc_lo[WIDTH-1]};
        diff      = shifted - {1'b0, dvs};
        sign_diff = op_sgn & (neg_a ^ neg_b);
        if (op_div) begin
            step_hi = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            step_hi = add_sum[WIDTH:1];
            step_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
        end
        prod = {step_hi, step_lo};
        if (sign_diff)
            prod = -prod;
        if (op_div) begin
            // Zero divisor leaves |srca| as remainder; restoring its sign yields srca.
            fin_lo = dz ? '1 : (sign_diff ? -step_lo : step_lo);
            fin_hi = (op_sgn & neg_a) ? -step_hi : step_hi;
        end else begin
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en && md_op) state_next = BUSY;
            BUSY:    if (cnt == CNT_W'(1)) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            dvs    <= '0;
            op_div <= 1'b0;
            op_sgn <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            dz     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && md_op) begin
                        op_div <= funct[1];
                        op_sgn <= ~funct[0];
                        neg_a  <= ~funct[0] & srca[WIDTH-1];
                        neg_b  <= ~funct[0] & srcb[WIDTH-1];
                        dz     <= (srcb == '0);
                        acc_hi <= '0;
                        acc_lo <= (~funct[0] & srca[WIDTH-1]) ? -srca : srca;
                        dvs    <= (~funct[0] & srcb[WIDTH-1]) ? -srcb : srcb;
                        cnt    <= CNT_W'(WIDTH);
                    end else if (en && is_mthi) begin
                        hi <= srca;
                    end else if (en && is_mtlo) begin
                        lo <= srca;
                    end
                end
                BUSY: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        hi <= fin_hi;
                        lo <= fin_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_decoder_md.sv
// tb/tb_alu_decoder_md.sv - randomized self-checking bench for alu_decoder_md
module tb_alu_decoder_md;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n, en;
    logic [1:0]   ALUOp;
    logic [5:0]   funct;
    logic [W-1:0] srca, srcb;
    logic [3:0]   ALUControl;
    logic         md_sel, stall, illegal;
    logic [W-1:0] md_result, hi, lo;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;

    always #5 clk = ~clk;

    alu_decoder_md #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ALUOp(ALUOp), .funct(funct),
        .srca(srca), .srcb(srcb), .ALUControl(ALUControl), .md_sel(md_sel),
        .md_result(md_result), .hi(hi), .lo(lo), .stall(stall), .illegal(illegal)
    );

    function automatic void ref_dec(input logic [1:0] op, input logic [5:0] f,
                                    output logic [3:0] ctl, output logic ill);
        ctl = 4'b0010;
        ill = 1'b0;
        if (op == 2'b01) ctl = 4'b0110;
        else if (op == 2'b11) ctl = 4'b0001;
        else if (op == 2'b10) begin
            case (f)
                6'h20, 6'h21: ctl = 4'b0010;
                6'h22, 6'h23: ctl = 4'b0110;
                6'h24: ctl = 4'b0000;
                6'h25: ctl = 4'b0001;
                6'h26: ctl = 4'b0011;
                6'h27: ctl = 4'b1100;
                6'h2a: ctl = 4'b0111;
                6'h2b: ctl = 4'b1111;
                6'h00: ctl = 4'b1000;
                6'h02: ctl = 4'b1001;
                6'h03: ctl = 4'b1010;
                6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b: ctl = 4'b0010;
                default: ill = 1'b1;
            endcase
        end
    endfunction

    function automatic logic [2*W-1:0] ref_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [2*W-1:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            6'h18: begin p = 64'(sa * sb); return p; end
            6'h19: begin p = {32'b0, a} * {32'b0, b}; return p; end
            default: begin
                if (b == '0) return {a, {W{1'b1}}};
                if (f == 6'h1a) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[W-1:0], q[W-1:0]};
                end
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic drive(input logic e, input logic [1:0] op, input logic [5:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        en = e; ALUOp = op; funct = f; srca = a; srcb = b;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 2'b10, 6'h18, $urandom, $urandom);
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        @(negedge clk);
        drive(1'b0, 2'b10, 6'h10, '0, '0);
        #1;
        checks++;
        if (hi !== '0 || lo !== '0 || md_result !== '0) begin
            errors++; $display("FAIL reset_hilo got hi=%h lo=%h md=%h exp=0", hi, lo, md_result);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_decode;
        logic [3:0] ctl;
        logic ill;
        logic [1:0] op;
        logic [5:0] f;
        logic [W-1:0] exp_md;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            op = 2'($urandom_range(0, 3));
            f  = 6'($urandom_range(0, 63));
            if (i == 0) begin op = 2'b10; f = 6'b100111; end
            if (i == 1) begin op = 2'b10; f = 6'b111111; end
            drive(1'b0, op, f, $urandom, $urandom);
            #1;
            ref_dec(op, f, ctl, ill);
            exp_md = (op == 2'b10 && f == 6'h10) ? m_hi : (op == 2'b10 && f == 6'h12) ? m_lo : '0;
            checks++;
            if (ALUControl !== ctl || illegal !== ill || stall !== 1'b0 ||
                md_sel !== (op == 2'b10 && (f == 6'h10 || f == 6'h12)) || md_result !== exp_md) begin
                errors++;
                $display("FAIL decode op=%b f=%b got ctl=%b ill=%b stall=%b sel=%b md=%h exp ctl=%b ill=%b md=%h",
                         op, f, ALUControl, illegal, stall, md_sel, md_result, ctl, ill, exp_md);
            end
        end
    endtask

    task automatic run_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        logic [2*W-1:0] r;
        @(negedge clk);
        drive(1'b1, 2'b10, f, a, b);
        #1;
        checks++;
        if (ALUControl !== 4'b0010 || illegal !== 1'b0) begin
            errors++; $display("FAIL md_ctl f=%b got ctl=%b ill=%b exp 0010/0", f, ALUControl, illegal);
        end
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        r = ref_md(f, a, b);
        m_hi = r[2*W-1:W];
        m_lo = r[W-1:0];
        checks++;
        if (n != W + 1) begin errors++; $display("FAIL md_stall_len f=%b got=%0d exp=%0d", f, n, W + 1); end
        checks++;
        if (hi !== m_hi || lo !== m_lo) begin
            errors++; $display("FAIL md_result f=%b a=%h b=%h got hi=%h lo=%h exp hi=%h lo=%h", f, a, b, hi, lo, m_hi, m_lo);
        end
        @(negedge clk);
        drive(1'b1, 2'b10, 6'h12, $urandom, $urandom);
        #1;
        checks++;
        if (stall !== 1'b0 || md_result !== m_lo || md_sel !== 1'b1) begin
            errors++; $display("FAIL mflo_after f=%b got stall=%b md=%h exp stall=0 md=%h", f, stall, md_result, m_lo);
        end
        @(negedge clk);
        drive(1'b1, 2'b10, 6'h10, $urandom, $urandom);
        #1;
        checks++;
        if (stall !== 1'b0 || md_result !== m_hi) begin
            errors++; $display("FAIL mfhi_after f=%b got stall=%b md=%h exp stall=0 md=%h", f, stall, md_result, m_hi);
        end
        en = 1'b0;
    endtask

    task automatic test_muldiv;
        run_md(6'h18, 32'hFFFFFFFE, 32'd3);
        run_md(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_md(6'h1a, 32'hFFFFFFF9, 32'd2);
        run_md(6'h1b, 32'd100, 32'd0);
        run_md(6'h1a, 32'h80000000, 32'hFFFFFFFF);
        run_md(6'h1a, 32'hFFFFFFF9, 32'd0);
        run_md(6'h1a, 32'd7, 32'hFFFFFFFE);
        for (int i = 0; i < 8; i++)
            run_md(6'(6'h18 + $urandom_range(0, 3)), $urandom, (i < 4) ? 32'($urandom_range(1, 999)) : $urandom);
    endtask

    task automatic test_mthi_mtlo;
        logic [W-1:0] v;
        @(negedge clk);
        drive(1'b1, 2'b10, 6'h11, 32'h1234, $urandom);
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL mthi_stall got=%b exp=0", stall); end
        m_hi = 32'h1234;
        @(negedge clk);
        drive(1'b1, 2'b10, 6'h10, $urandom, $urandom);
        #1;
        checks++;
        if (md_result !== 32'h1234) begin errors++; $display("FAIL mthi_mfhi got=%h exp=%h", md_result, 32'h1234); end
        v = $urandom;
        @(negedge clk);
        drive(1'b1, 2'b10, 6'h13, v, $urandom);
        m_lo = v;
        @(negedge clk);
        drive(1'b1, 2'b10, 6'h12, $urandom, $urandom);
        #1;
        checks++;
        if (md_result !== v || hi !== 32'h1234) begin
            errors++; $display("FAIL mtlo_mflo got md=%h hi=%h exp md=%h hi=%h", md_result, hi, v, 32'h1234);
        end
        en = 1'b0;
    endtask

    task automatic test_reset_mid_busy;
        @(negedge clk);
        drive(1'b1, 2'b10, 6'h18, 32'hFFFFFFFE, 32'd3);
        for (int i = 0; i < 10; i++) @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL busy_before_reset got stall=%b exp=1", stall); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_forces_stall got=%b exp=0", stall); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 2'b00, 6'h00, '0, '0);
        m_hi = '0;
        m_lo = '0;
        #1;
        checks++;
        if (stall !== 1'b0 || hi !== '0 || lo !== '0) begin
            errors++; $display("FAIL reset_mid_busy got stall=%b hi=%h lo=%h exp 0/0/0", stall, hi, lo);
        end
        @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_discard got stall=%b exp=0", stall); end
        run_md(6'h18, 32'hFFFFFFFE, 32'd3);
    endtask

    task automatic test_back_to_back;
        run_md(6'h19, $urandom, $urandom);
        run_md(6'h1b, $urandom, 32'($urandom_range(1, 65535)));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 2'b00, 6'h00, '0, '0);
        test_reset;
        test_decode;
        test_muldiv;
        test_mthi_mtlo;
        test_reset_mid_busy;
        test_back_to_back;
        test_decode;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
